pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit processor: sequences fetch, decode/register-read, execute and writeback for each instruction.
- Owns the program-counter register. The PC advances by exactly one per retired instruction; there is no branch or jump support.
- Sits between instruction memory, register file and ALU.
- Issues the register-read flag that downstream blocks wait on, plus the memory, ALU and writeback strobes.

Parameters:
- PC_WIDTH, 8, width of program counter / instruction index.
- EXEC_CYCLES, 1, number of cycles alu_en is held per instruction (legal 1..15).
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level/pulse; leaves IDLE when sampled high.
- stall  input  1  freeze request from downstream; holds FSM in current state.
- instr_valid  input  1  instruction memory data ready for current pc.
- is_halt  input  1  decoded halt opcode, sampled in DECODE only.
- pc  output  PC_WIDTH  current instruction index driven to instruction memory.
- imem_rd_en  output  1  instruction memory read request.
- reg_rd_flag  output  1  register-file read strobe.
- alu_en  output  1  execute enable.
- reg_wr_en  output  1  register writeback strobe.
- busy  output  1  high in any state other than IDLE/HALTED.
- halted  output  1  high in HALTED.
- pc_wrap  output  1  sticky; set when pc wraps from max to 0.
- instr_count  output  CNT_WIDTH  retired instructions, saturating.

Behaviour:
- Single clock domain; synchronous active-high reset.
- Reset (including mid-operation): state=IDLE, pc=0, exec counter=0, instr_count=0, pc_wrap=0. All strobes, busy and halted are 0 in the cycle after reset is sampled.
- Strobe outputs are Moore-decoded from the registered state. pc, pc_wrap and instr_count are registers.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE: all strobes 0. Go to FETCH when start=1.
- FETCH: imem_rd_en=1. Go to DECODE on the cycle instr_valid=1; otherwise hold, with imem_rd_en held and pc unchanged.
- DECODE: reg_rd_flag=1 for one cycle.
  - is_halt=1: go to HALTED; pc not incremented; instr_count not incremented.
  - Otherwise: go to EXECUTE and load the exec counter with EXEC_CYCLES-1.
- EXECUTE: alu_en=1. If counter=0, go to WRITEBACK; otherwise decrement.
- WRITEBACK: reg_wr_en=1 for one cycle. In that cycle:
  - pc <= pc+1, modulo 2^PC_WIDTH.
  - instr_count increments, saturating at all-ones.
  - If pc was all-ones, pc becomes 0 and pc_wrap is set; pc_wrap stays set until reset.
  - Next state is FETCH; there is no return to IDLE.
- HALTED: all strobes 0, halted=1, pc frozen. start is ignored; only reset exits.
- stall=1:
  - The state register, exec counter, pc and instr_count hold.
  - All strobes (imem_rd_en, reg_rd_flag, alu_en, reg_wr_en) are forced to 0.
  - busy keeps its state-decoded value.
  - On stall release the current state's strobe reasserts, so one-shot strobes fire exactly once per instruction.
- stall has no effect in IDLE or HALTED. start is still honoured in IDLE when stall=1, and the FSM enters FETCH.
- Simultaneous stall and instr_valid in FETCH: stall wins and the FSM stays in FETCH.
- Simultaneous reset with anything: reset wins.
- Nominal latency with EXEC_CYCLES=1, instr_valid=1 and no stall is 4 cycles per instruction. pc changes on the clock edge ending WRITEBACK.
- Throughput: 3+EXEC_CYCLES cycles per instruction plus memory wait and stall cycles.

Test Plan:
- Reset, one-cycle start pulse, instr_valid=1, is_halt=0:
  - States visited are FETCH, DECODE, EXECUTE, WRITEBACK.
  - imem_rd_en, reg_rd_flag, alu_en and reg_wr_en each pulse exactly 1 cycle, in that order.
  - pc goes 0→1 four cycles after entering FETCH; pc=3 after 12 cycles; instr_count=3.
- instr_valid held low 3 cycles in FETCH: imem_rd_en high 4 consecutive cycles, pc constant, DECODE entered on the 4th.
- EXEC_CYCLES=3: alu_en high exactly 3 consecutive cycles per instruction; per-instruction period is 6 cycles.
- Halt: is_halt=1 in DECODE when pc=5:
  - Next cycle halted=1, busy=0.
  - pc stays 5, instr_count=5, no reg_wr_en.
  - A later start pulse causes no change.
- Wrap: run 256 instructions from pc=0. pc returns to 0x00, pc_wrap=1 and stays 1; instr_count=256.
- stall=1 for 2 cycles while in WRITEBACK: reg_wr_en low during the stall, then high exactly 1 cycle after release; pc increments exactly once.
- reset asserted for 1 cycle while in EXECUTE at pc=7: next cycle state IDLE, pc=0, instr_count=0, pc_wrap=0, all strobes 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Multi-cycle control FSM for the 8-bit processor. Each instruction goes
// through FETCH -> DECODE -> EXECUTE (EXEC_CYCLES cycles) -> WRITEBACK. The
// block owns the program counter, which advances by one per retired
// instruction. There are no branches or jumps. A decoded halt parks the FSM in
// HALTED until reset.
//
// Ports
//   i_clk          system clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset
//   i_start        leaves IDLE when sampled high
//   i_stall        freezes state, pc and counters and masks all strobes
//   i_instr_valid  instruction memory data ready for the current pc
//   i_is_halt      decoded halt opcode, only looked at in DECODE
//   o_pc           current instruction index to instruction memory
//   o_imem_rd_en   instruction memory read request (FETCH)
//   o_reg_rd_flag  register-file read strobe (DECODE)
//   o_alu_en       execute enable (EXECUTE)
//   o_reg_wr_en    register writeback strobe (WRITEBACK)
//   o_busy         high in every state except IDLE and HALTED
//   o_halted       high in HALTED
//   o_pc_wrap      sticky flag, set when pc rolls over from all-ones to zero
//   o_instr_count  retired-instruction count, saturating at all-ones
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_stall,
    input  logic                 i_instr_valid,
    input  logic                 i_is_halt,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic                 o_imem_rd_en,
    output logic                 o_reg_rd_flag,
    output logic                 o_alu_en,
    output logic                 o_reg_wr_en,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_pc_wrap,
    output logic [CNT_WIDTH-1:0] o_instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    // The exec counter counts down the remaining EXECUTE cycles; EXEC_CYCLES
    // is at most 15, so four bits always suffice.
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [3:0]             r_exec_cnt;
    logic [3:0]             w_exec_cnt_next;
    logic                   w_retire;
    logic [PC_WIDTH-1:0]    r_pc;
    logic                   r_pc_wrap;
    logic [CNT_WIDTH-1:0]   r_instr_count;

    // Saturating increment: once the count reaches all-ones it sticks there.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // Next-state logic. stall only freezes the instruction-processing states;
    // IDLE still honours start and HALTED cannot be left anyway.
    always_comb begin
        w_next_state    = r_state;
        w_exec_cnt_next = r_exec_cnt;
        w_retire        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                // stall beats a simultaneous instr_valid
                if (!i_stall && i_instr_valid) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!i_stall) begin
                    if (i_is_halt) begin
                        w_next_state = S_HALTED;
                    end else begin
                        w_next_state    = S_EXECUTE;
                        w_exec_cnt_next = EXEC_LOAD;
                    end
                end
            end
            S_EXECUTE: begin
                if (!i_stall) begin
                    if (r_exec_cnt == 4'd0) begin
                        w_next_state = S_WRITEBACK;
                    end else begin
                        w_exec_cnt_next = r_exec_cnt - 4'd1;
                    end
                end
            end
            S_WRITEBACK: begin
                if (!i_stall) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, pc and counters. pc and instr_count only move when an
    // instruction actually retires, i.e. on the edge ending an unstalled
    // WRITEBACK cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_exec_cnt    <= 4'd0;
            r_pc          <= '0;
            r_pc_wrap     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_exec_cnt <= w_exec_cnt_next;
            if (w_retire) begin
                r_pc          <= r_pc + PC_WIDTH'(1);
                r_instr_count <= sat_inc(r_instr_count);
                if (&r_pc) begin
                    r_pc_wrap <= 1'b1;
                end
            end
        end
    end

    // Strobes are decoded from the registered state and masked by stall, so a
    // stalled one-shot strobe fires exactly once when the stall is released.
    assign o_imem_rd_en  = (r_state == S_FETCH)     && !i_stall;
    assign o_reg_rd_flag = (r_state == S_DECODE)    && !i_stall;
    assign o_alu_en      = (r_state == S_EXECUTE)   && !i_stall;
    assign o_reg_wr_en   = (r_state == S_WRITEBACK) && !i_stall;

    assign o_busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign o_halted      = (r_state == S_HALTED);
    assign o_pc          = r_pc;
    assign o_pc_wrap     = r_pc_wrap;
    assign o_instr_count = r_instr_count;

endmodule
